row_compressor: RTL and testbench

Sequential run-length encoder for one feature-map row. It is the transmit-side counterpart of the IO module's decompressor. It scans a raw row LSB-first, one bit per clock, and packs alternating run lengths into fixed-width sections. The packed word is exactly the format the decompressor expands back into the original row. It sits in the IO module on the output path, between the accelerator result rows and the external memory interface.

---
 rtl/row_compressor_pkg.sv | 19 +
 rtl/row_compressor_section_packer.sv | 62 ++++++
 rtl/row_compressor.sv | 149 ++++++++++++++
 tb/tb_row_compressor.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/row_compressor_pkg.sv
// Shared constants and FSM encoding for the row run-length compressor and its
// decompressor counterpart.
package row_compressor_pkg;

  localparam int SECTION_SIZE = 4;
  localparam int ROW_SIZE     = 16;
  localparam int NUM_SECTIONS = ROW_SIZE / SECTION_SIZE;
  localparam int MAX_RUN      = (1 << SECTION_SIZE) - 1;
  localparam int RUN_W        = SECTION_SIZE + 1;
  localparam int COUNT_W      = $clog2(ROW_SIZE * 2) + 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    FLUSH,
    DONE
  } state_e;

endpackage

// File: rtl/row_compressor_section_packer.sv
// Packs run-length sections into the compressed word; writes past the last
// section are dropped but still counted.
module section_packer #(
  parameter int sectionSize = 4,
  parameter int rowSize     = 16,
  parameter int countW      = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic [1:0]             wr_num,
  input  logic [sectionSize-1:0] sec_a,
  input  logic [sectionSize-1:0] sec_b,
  input  logic                   trunc,
  input  logic [countW-1:0]      trunc_idx,
  output logic [rowSize-1:0]     data,
  output logic [countW-1:0]      count
);

  localparam int NumSections = rowSize / sectionSize;

  logic [rowSize-1:0] data_next;
  logic [countW-1:0]  count_next;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    data_next  = data;
    count_next = count;
    if (clear) begin
      data_next  = '0;
      count_next = '0;
    end else if (trunc) begin
      for (int i = 0; i < NumSections; i++) begin
        if (i >= int'(trunc_idx)) data_next[i*sectionSize +: sectionSize] = '0;
      end
      count_next = trunc_idx;
    end else begin
      // Sections beyond capacity fall through the loop and are dropped.
      for (int i = 0; i < NumSections; i++) begin
        if (wr_num != 2'd0 && int'(count) == i)
          data_next[i*sectionSize +: sectionSize] = sec_a;
        if (wr_num == 2'd2 && int'(count) + 1 == i)
          data_next[i*sectionSize +: sectionSize] = sec_b;
      end
      count_next = count + countW'(wr_num);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      count <= '0;
    end else begin
      data  <= data_next;
      count <= count_next;
    end
  end

endmodule

// File: rtl/row_compressor.sv
// Run-length encoder for one feature-map row: scans LSB-first, one bit per
// clock, and emits alternating 0/1 run lengths into fixed-width sections.
module row_compressor
  import row_compressor_pkg::*;
#(
  parameter int sectionSize = SECTION_SIZE,
  parameter int rowSize     = ROW_SIZE
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [rowSize-1:0]          rawData,
  output logic                        busy,
  output logic                        done,
  output logic [rowSize-1:0]          compressedData,
  output logic [$clog2(rowSize*2):0]  sectionCount,
  output logic                        overflow
);

  localparam int NumSections = rowSize / sectionSize;
  localparam int RunW        = sectionSize + 1;
  localparam int CountW      = $clog2(rowSize * 2) + 1;
  localparam int BitW        = $clog2(rowSize);
  localparam logic [RunW-1:0] RunMax  = RunW'((1 << sectionSize) - 1);
  localparam logic [BitW-1:0] LastBit = BitW'(rowSize - 1);

  state_e                   state, state_next;
  logic [rowSize-1:0]       shift;
  logic [RunW-1:0]          run;
  logic                     digit;
  logic [CountW-1:0]        zero_start;
  logic [BitW-1:0]          bit_idx;
  logic                     overflow_r;

  logic                     clear;
  logic [1:0]               wr_num;
  logic [sectionSize-1:0]   sec_a, sec_b;
  logic                     trunc;
  logic [CountW-1:0]        count;
  logic [CountW-1:0]        final_count;

  section_packer #(
    .sectionSize (sectionSize),
    .rowSize     (rowSize),
    .countW      (CountW)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .wr_num    (wr_num),
    .sec_a     (sec_a),
    .sec_b     (sec_b),
    .trunc     (trunc),
    .trunc_idx (zero_start),
    .data      (compressedData),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    clear       = 1'b0;
    wr_num      = 2'd0;
    sec_a       = '0;
    sec_b       = '0;
    trunc       = 1'b0;
    final_count = digit ? count + CountW'(1) : zero_start;
    unique case (state)
      IDLE: begin
        if (start) begin
          clear      = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (shift[0] != digit) begin
          wr_num = 2'd1;
          sec_a  = run[sectionSize-1:0];
        end else if (run == RunMax) begin
          // Saturated run: close it and insert an empty opposite-digit run.
          wr_num = 2'd2;
          sec_a  = RunMax[sectionSize-1:0];
        end
        if (bit_idx == LastBit) state_next = FLUSH;
      end
      FLUSH: begin
        if (digit) begin
          wr_num = 2'd1;
          sec_a  = run[sectionSize-1:0];
        end else begin
          trunc = 1'b1;
        end
        state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift      <= '0;
      run        <= '0;
      digit      <= 1'b0;
      zero_start <= '0;
      bit_idx    <= '0;
      overflow_r <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            shift      <= rawData;
            run        <= '0;
            digit      <= 1'b0;
            zero_start <= '0;
            bit_idx    <= '0;
            overflow_r <= 1'b0;
          end
        end
        SCAN: begin
          shift   <= shift >> 1;
          bit_idx <= bit_idx + BitW'(1);
          if (shift[0] != digit) begin
            digit <= shift[0];
            run   <= RunW'(1);
            // A new 0-run starts right after the section just written.
            if (!shift[0]) zero_start <= count + CountW'(1);
          end else if (run == RunMax) begin
            run <= RunW'(1);
          end else begin
            run <= run + RunW'(1);
          end
        end
        FLUSH:   overflow_r <= final_count > CountW'(NumSections);
        default: ;
      endcase
    end
  end

  assign busy         = (state == SCAN) || (state == FLUSH);
  assign done         = (state == DONE);
  assign sectionCount = count;
  assign overflow     = overflow_r;

endmodule

// File: tb/tb_row_compressor.sv
// Directed self-checking bench for row_compressor: encoding vectors, latency,
// ignored start, mid-scan reset and back-to-back rows.
module tb_row_compressor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] rawData = '0;
  logic        busy;
  logic        done;
  logic [15:0] compressedData;
  logic [5:0]  sectionCount;
  logic        overflow;

  int tests_run = 0;
  int tests_failed = 0;

  row_compressor dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .rawData        (rawData),
    .busy           (busy),
    .done           (done),
    .compressedData (compressedData),
    .sectionCount   (sectionCount),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  // Reference expansion of a packed word back into a row.
  function automatic logic [15:0] decompress(input logic [15:0] d, input logic [5:0] c);
    logic [15:0] r;
    int pos;
    int len;
    r = '0;
    pos = 0;
    for (int s = 0; s < 4; s++) begin
      if (s < int'(c)) begin
        len = int'(d[s*4 +: 4]);
        for (int j = 0; j < len; j++) begin
          if (pos < 16) r[pos] = s[0];
          pos++;
        end
      end
    end
    return r;
  endfunction

  // Starts a row in the IDLE cycle and waits for done; lat is the cycle
  // number (cycle 1 follows the accepting edge) in which done is seen, 0 on timeout.
  task automatic run_row(input logic [15:0] raw, output int lat, output logic busy1,
                         output logic busy_done, output logic [15:0] d,
                         output logic [5:0] c, output logic o);
    @(negedge clk);
    start = 1'b1;
    rawData = raw;
    @(negedge clk);
    start = 1'b0;
    busy1 = busy;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    busy_done = busy;
    d = compressedData;
    c = sectionCount;
    o = overflow;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({busy, done, overflow, compressedData, sectionCount} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got busy=%b done=%b ovf=%b data=%h count=%0d, expected all zero",
               busy, done, overflow, compressedData, sectionCount);
    end
    rst = 1'b0;
  endtask

  task automatic test_encode(input string name, input logic [15:0] raw,
                             input logic [15:0] exp_d, input logic [5:0] exp_c,
                             input logic exp_o);
    int lat;
    logic b1, bd, o;
    logic [15:0] d;
    logic [5:0] c;
    run_row(raw, lat, b1, bd, d, c, o);
    tests_run++;
    if (lat !== 18) begin
      tests_failed++;
      $display("FAIL %s latency: got %0d expected 18", name, lat);
    end
    tests_run++;
    if ({b1, bd} !== 2'b10) begin
      tests_failed++;
      $display("FAIL %s busy: got first=%b at_done=%b expected 1/0", name, b1, bd);
    end
    tests_run++;
    if (d !== exp_d) begin
      tests_failed++;
      $display("FAIL %s data: got %h expected %h", name, d, exp_d);
    end
    tests_run++;
    if (c !== exp_c || o !== exp_o) begin
      tests_failed++;
      $display("FAIL %s count/ovf: got %0d/%b expected %0d/%b", name, c, o, exp_c, exp_o);
    end
    if (!exp_o) begin
      tests_run++;
      if (decompress(d, c) !== raw) begin
        tests_failed++;
        $display("FAIL %s roundtrip: got %h expected %h", name, decompress(d, c), raw);
      end
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    int extra;
    @(negedge clk);
    start = 1'b1;
    rawData = 16'h00F0;
    @(negedge clk);
    start = 1'b0;
    rawData = 16'h0000;
    lat = 0;
    extra = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) start = 1'b1;
      if (k == 5) rawData = 16'hFFFF;
      if (k == 6) start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    tests_run++;
    if (lat !== 18 || compressedData !== 16'h0044 || sectionCount !== 6'd2) begin
      tests_failed++;
      $display("FAIL start_ignored: got lat=%0d data=%h count=%0d expected 18/0044/2",
               lat, compressedData, sectionCount);
    end
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done) extra++;
    end
    tests_run++;
    if (extra !== 0) begin
      tests_failed++;
      $display("FAIL start_ignored_extra_done: got %0d pulses expected 0", extra);
    end
  endtask

  task automatic test_reset_mid_scan();
    int pulses;
    @(negedge clk);
    start = 1'b1;
    rawData = 16'h0033;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if ({busy, done, overflow, compressedData, sectionCount} !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_scan: got busy=%b done=%b ovf=%b data=%h count=%0d, expected all zero",
               busy, done, overflow, compressedData, sectionCount);
    end
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    tests_run++;
    if (pulses !== 0) begin
      tests_failed++;
      $display("FAIL reset_mid_scan_done: got %0d pulses expected 0", pulses);
    end
  endtask

  task automatic test_back_to_back();
    // The second start lands in the IDLE cycle right after done.
    test_encode("b2b_first", 16'h0001, 16'h0010, 6'd2, 1'b0);
    test_encode("b2b_second", 16'h00F0, 16'h0044, 6'd2, 1'b0);
  endtask

  initial begin
    test_reset();
    test_encode("all_zero", 16'h0000, 16'h0000, 6'd0, 1'b0);
    test_encode("mid_ones", 16'h00F0, 16'h0044, 6'd2, 1'b0);
    test_encode("lead_ones", 16'h000F, 16'h0040, 6'd2, 1'b0);
    test_encode("all_ones", 16'hFFFF, 16'h10F0, 6'd4, 1'b0);
    test_encode("alternating", 16'h5555, 16'h1110, 6'd16, 1'b1);
    test_encode("max_zero_run", 16'h8000, 16'h001F, 6'd2, 1'b0);
    test_encode("max_one_run", 16'hFFFE, 16'h00F1, 6'd2, 1'b0);
    test_encode("ends_ones", 16'h8001, 16'h1E10, 6'd4, 1'b0);
    test_start_ignored();
    test_reset_mid_scan();
    test_encode("after_reset", 16'h000F, 16'h0040, 6'd2, 1'b0);
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
